// File: rtl/mult_seq_digit.sv
// Sequential WIDTH x WIDTH multiplier built around one DIGIT x DIGIT core.
// The FSM steps through every digit pair of the captured operand magnitudes,
// shift-accumulates each partial product, then applies the result sign once.
module mult_seq_digit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned K   = WIDTH / DIGIT;
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned PPW = 2 * DIGIT;
  localparam int unsigned CW  = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     i_q, i_d;
  logic [CW-1:0]     j_q, j_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PW-1:0]     out_q, out_d;

  logic [WIDTH-1:0]  a_mag_c;
  logic [WIDTH-1:0]  b_mag_c;
  logic [DIGIT-1:0]  a_dig_c;
  logic [DIGIT-1:0]  b_dig_c;
  logic [PPW-1:0]    pp_c;
  logic [PW-1:0]     pp_sh_c;

  // Operand magnitudes at the input; -(most negative) wraps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag_c = in1;
    b_mag_c = in2;
    if (sgn && in1[WIDTH-1]) a_mag_c = WIDTH'(-in1);
    if (sgn && in2[WIDTH-1]) b_mag_c = WIDTH'(-in2);
  end

  // Digit select, the single DIGIT x DIGIT core, and placement of its product.
  always_comb begin
    a_dig_c = DIGIT'(a_q >> (DIGIT * 32'(i_q)));
    b_dig_c = DIGIT'(b_q >> (DIGIT * 32'(j_q)));
    pp_c    = PPW'(a_dig_c) * PPW'(b_dig_c);
    pp_sh_c = PW'(pp_c) << (DIGIT * (32'(i_q) + 32'(j_q)));
  end

  // Next-state and datapath update; j is the inner digit index, i the outer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_mag_c;
          b_d     = b_mag_c;
          neg_d   = sgn & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + pp_sh_c;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            state_d = S_FIX;
          end else begin
            i_d = i_q + ONE;
          end
        end else begin
          j_d = j_q + ONE;
        end
      end
      S_FIX: begin
        out_d   = neg_q ? PW'(-acc_q) : acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_mult_seq_digit.sv
// Randomised scoreboard bench for mult_seq_digit (WIDTH=8, DIGIT=2).
// Stimulus pushes expected products; a forked monitor pops them on each done.
module tb_mult_seq_digit;

  localparam int unsigned LAT = 17;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int          n_chk;
  int          n_fail;
  int          cyc;
  logic [15:0] exp_q[$];
  int          acc_cyc_q[$];

  mult_seq_digit #(.WIDTH(8), .DIGIT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference product from plain integer arithmetic.
  function automatic logic [15:0] model(bit s, logic [7:0] a, logic [7:0] b);
    longint pa;
    longint pb;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    return 16'(pa * pb);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endfunction

  // Pops the scoreboard whenever the DUT presents a result.
  task automatic monitor();
    logic        prev_done;
    logic [15:0] e;
    int          c;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (prev_done) fail_now("done_width");
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          c = acc_cyc_q.pop_front();
          check("product", 32'(out), 32'(e));
          check("latency", 32'(cyc - c), 32'(LAT));
        end
      end
      prev_done = done;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic issue(bit s, logic [7:0] a, logic [7:0] b);
    sgn   = s;
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(s, a, b));
    acc_cyc_q.push_back(cyc);
    start = 1'b0;
    in1   = 8'($urandom);
    in2   = 8'($urandom);
    sgn   = 1'($urandom);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] corners[4];
    logic [7:0] ra;
    logic [7:0] rb;
    corners[0] = 8'h00;
    corners[1] = 8'h80;
    corners[2] = 8'h7F;
    corners[3] = 8'hFF;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst    = 1'b0;
    start  = 1'b0;
    sgn    = 1'b0;
    in1    = 8'h00;
    in2    = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    fork
      monitor();
    join_none

    // Directed products including the most-negative corners.
    issue(1'b0, 8'hFF, 8'hFF); wait_idle();
    issue(1'b1, 8'hFD, 8'h05); wait_idle();
    issue(1'b1, 8'h80, 8'h80); wait_idle();
    issue(1'b1, 8'h80, 8'h7F); wait_idle();
    drain();

    // Start while busy is ignored; only one done and out holds afterwards.
    issue(1'b0, 8'd6, 8'd7);
    repeat (4) @(negedge clk);
    sgn = 1'b0; in1 = 8'd9; in2 = 8'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    wait_idle();
    drain();
    repeat (20) @(negedge clk);
    check("held_out", 32'(out), 32'd42);

    // Back-to-back: start held high through done is accepted in the done cycle.
    sgn = 1'b0; in1 = 8'd13; in2 = 8'd11; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(1'b0, 8'd13, 8'd11));
    acc_cyc_q.push_back(cyc);
    @(negedge clk);
    sgn = 1'b1; in1 = 8'hF0; in2 = 8'h21;
    begin
      int n;
      n = 0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!done) fail_now("b2b_done_timeout");
    end
    @(posedge clk);
    #1;
    exp_q.push_back(model(1'b1, 8'hF0, 8'h21));
    acc_cyc_q.push_back(cyc);
    start = 1'b0;
    @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_idle();
    drain();

    // Reset mid-operation clears outputs at once; next op is correct.
    issue(1'b0, 8'd200, 8'd200);
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    void'(exp_q.pop_back());
    void'(acc_cyc_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 8'd200, 8'd200);
    wait_idle();
    drain();

    // Randomised operations with corner operands mixed in.
    for (int k = 0; k < 40; k++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
      issue(1'($urandom), ra, rb);
    end
    wait_idle();
    drain();
    repeat (25) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
